// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared hazard-controller types and constants
package pipeline_pkg;

   typedef enum logic [1:0] {RUN, LOADSTALL, FLUSH} hazState_t;

   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_WB      = 2'b01;
   localparam logic [1:0] FWD_MEM     = 2'b10;

   localparam int PCREG = 15;

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - combinational operand-forwarding select for one execute operand
module forward_unit
   import pipeline_pkg::*;
#(
   parameter int ADDRESSWIDTH = 4,
   parameter int PCREG        = pipeline_pkg::PCREG
) (
   input  logic [ADDRESSWIDTH-1:0] exRegAddress,
   input  logic [ADDRESSWIDTH-1:0] memDestAddress,
   input  logic                    memRegWrite,
   input  logic [ADDRESSWIDTH-1:0] wbDestAddress,
   input  logic                    wbRegWrite,
   output logic [1:0]              forwardSelect
);

   localparam logic [ADDRESSWIDTH-1:0] PC_ADDR = ADDRESSWIDTH'(PCREG);

   logic isPc;

   assign isPc = (exRegAddress == PC_ADDR);

   // Memory stage holds the younger result, so it wins over writeback.
   always_comb begin
      forwardSelect = FWD_REGFILE;
      if (!isPc && memRegWrite && (memDestAddress == exRegAddress)) begin
         forwardSelect = FWD_MEM;
      end else if (!isPc && wbRegWrite && (wbDestAddress == exRegAddress)) begin
         forwardSelect = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - load-use stall, redirect flush, forwarding and lost-cycle count
module hazard_controller
   import pipeline_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int ADDRESSWIDTH    = 4,
   parameter int PCREG           = pipeline_pkg::PCREG,
   parameter int FLUSHCYCLES     = 2,
   parameter int STALLCOUNTWIDTH = 2 * WIDTH
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [ADDRESSWIDTH-1:0]    decReg1Address,
   input  logic [ADDRESSWIDTH-1:0]    decReg2Address,
   input  logic                       decUsesReg1,
   input  logic                       decUsesReg2,
   input  logic [ADDRESSWIDTH-1:0]    exReg1Address,
   input  logic [ADDRESSWIDTH-1:0]    exReg2Address,
   input  logic [ADDRESSWIDTH-1:0]    exDestAddress,
   input  logic [ADDRESSWIDTH-1:0]    memDestAddress,
   input  logic [ADDRESSWIDTH-1:0]    wbDestAddress,
   input  logic                       exRegWrite,
   input  logic                       memRegWrite,
   input  logic                       wbRegWrite,
   input  logic                       exIsLoad,
   input  logic                       branchTaken,
   output logic                       stallFetch,
   output logic                       stallDecode,
   output logic                       flushDecode,
   output logic                       flushExecute,
   output logic [1:0]                 forward1Select,
   output logic [1:0]                 forward2Select,
   output logic [STALLCOUNTWIDTH-1:0] lostCycles
);

   localparam logic [ADDRESSWIDTH-1:0] PC_ADDR    = ADDRESSWIDTH'(PCREG);
   localparam logic [1:0]              FLUSH_LOAD = 2'(FLUSHCYCLES - 1);

   hazState_t  state, nextState;
   logic [1:0] flushCount, nextFlushCount;
   logic       luHaz;

   assign luHaz = exIsLoad && exRegWrite && (exDestAddress != PC_ADDR) &&
                  ((decUsesReg1 && (decReg1Address == exDestAddress)) ||
                   (decUsesReg2 && (decReg2Address == exDestAddress)));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= RUN;
         flushCount <= 2'd0;
      end else begin
         state      <= nextState;
         flushCount <= nextFlushCount;
      end
   end

   // LOADSTALL shares the redirect path with RUN but never re-stalls on the same load.
   always_comb begin
      nextState      = state;
      nextFlushCount = flushCount;
      stallFetch     = 1'b0;
      stallDecode    = 1'b0;
      flushDecode    = 1'b0;
      flushExecute   = 1'b0;
      case (state)
         RUN, LOADSTALL: begin
            nextState = RUN;
            if (branchTaken) begin
               flushDecode  = 1'b1;
               flushExecute = 1'b1;
               if (FLUSHCYCLES > 1) begin
                  nextState      = FLUSH;
                  nextFlushCount = FLUSH_LOAD;
               end
            end else if ((state == RUN) && luHaz) begin
               stallFetch   = 1'b1;
               stallDecode  = 1'b1;
               flushExecute = 1'b1;
               nextState    = LOADSTALL;
            end
         end
         FLUSH: begin
            flushDecode    = 1'b1;
            flushExecute   = 1'b1;
            nextFlushCount = flushCount - 2'd1;
            if (flushCount <= 2'd1) begin
               nextState      = RUN;
               nextFlushCount = 2'd0;
            end
         end
         default: begin
            nextState      = RUN;
            nextFlushCount = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lostCycles <= '0;
      end else if ((stallFetch || flushExecute) && (lostCycles != '1)) begin
         lostCycles <= lostCycles + STALLCOUNTWIDTH'(1);
      end
   end

   forward_unit #(.ADDRESSWIDTH(ADDRESSWIDTH), .PCREG(PCREG)) u_fwd1 (
      .exRegAddress   (exReg1Address),
      .memDestAddress (memDestAddress),
      .memRegWrite    (memRegWrite),
      .wbDestAddress  (wbDestAddress),
      .wbRegWrite     (wbRegWrite),
      .forwardSelect  (forward1Select)
   );

   forward_unit #(.ADDRESSWIDTH(ADDRESSWIDTH), .PCREG(PCREG)) u_fwd2 (
      .exRegAddress   (exReg2Address),
      .memDestAddress (memDestAddress),
      .memRegWrite    (memRegWrite),
      .wbDestAddress  (wbDestAddress),
      .wbRegWrite     (wbRegWrite),
      .forwardSelect  (forward2Select)
   );

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - self-checking bench for hazard_controller
module tb_hazard_controller;

   typedef struct packed {
      logic [3:0] d1;
      logic       u1;
      logic [3:0] d2;
      logic       u2;
      logic [3:0] e1;
      logic [3:0] e2;
      logic [3:0] ed;
      logic       ew;
      logic       ld;
      logic [3:0] md;
      logic       mw;
      logic [3:0] wd;
      logic       ww;
      logic       br;
   } in_t;

   typedef struct packed {
      logic        sf;
      logic        sd;
      logic        fd;
      logic        fe;
      logic [1:0]  f1;
      logic [1:0]  f2;
      logic [15:0] lost;
   } out_t;

   typedef struct {
      in_t   i;
      out_t  o;
      string nm;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  decReg1Address, decReg2Address, exReg1Address, exReg2Address;
   logic [3:0]  exDestAddress, memDestAddress, wbDestAddress;
   logic        decUsesReg1, decUsesReg2, exRegWrite, memRegWrite, wbRegWrite;
   logic        exIsLoad, branchTaken;
   logic        stallFetch, stallDecode, flushDecode, flushExecute;
   logic [1:0]  forward1Select, forward2Select;
   logic [15:0] lostCycles;

   int checks = 0;
   int errors = 0;
   out_t sb[$];

   always #5 clock = ~clock;

   hazard_controller #(
      .WIDTH(8), .ADDRESSWIDTH(4), .PCREG(15), .FLUSHCYCLES(2), .STALLCOUNTWIDTH(16)
   ) dut (
      .clock(clock), .reset(reset),
      .decReg1Address(decReg1Address), .decReg2Address(decReg2Address),
      .decUsesReg1(decUsesReg1), .decUsesReg2(decUsesReg2),
      .exReg1Address(exReg1Address), .exReg2Address(exReg2Address),
      .exDestAddress(exDestAddress), .memDestAddress(memDestAddress),
      .wbDestAddress(wbDestAddress), .exRegWrite(exRegWrite),
      .memRegWrite(memRegWrite), .wbRegWrite(wbRegWrite),
      .exIsLoad(exIsLoad), .branchTaken(branchTaken),
      .stallFetch(stallFetch), .stallDecode(stallDecode),
      .flushDecode(flushDecode), .flushExecute(flushExecute),
      .forward1Select(forward1Select), .forward2Select(forward2Select),
      .lostCycles(lostCycles)
   );

   function automatic in_t fi(logic [3:0] d1, logic u1, logic [3:0] d2, logic u2,
                              logic [3:0] e1, logic [3:0] e2, logic [3:0] ed, logic ew,
                              logic ld, logic [3:0] md, logic mw, logic [3:0] wd,
                              logic ww, logic br);
      in_t r;
      r.d1 = d1; r.u1 = u1; r.d2 = d2; r.u2 = u2; r.e1 = e1; r.e2 = e2;
      r.ed = ed; r.ew = ew; r.ld = ld; r.md = md; r.mw = mw; r.wd = wd;
      r.ww = ww; r.br = br;
      return r;
   endfunction

   function automatic out_t fo(logic sf, logic sd, logic fd, logic fe,
                               logic [1:0] f1, logic [1:0] f2, logic [15:0] lost);
      out_t r;
      r.sf = sf; r.sd = sd; r.fd = fd; r.fe = fe; r.f1 = f1; r.f2 = f2; r.lost = lost;
      return r;
   endfunction

   task automatic drive(input in_t i);
      decReg1Address = i.d1; decUsesReg1 = i.u1;
      decReg2Address = i.d2; decUsesReg2 = i.u2;
      exReg1Address  = i.e1; exReg2Address = i.e2;
      exDestAddress  = i.ed; exRegWrite    = i.ew; exIsLoad = i.ld;
      memDestAddress = i.md; memRegWrite   = i.mw;
      wbDestAddress  = i.wd; wbRegWrite    = i.ww;
      branchTaken    = i.br;
   endtask

   task automatic compare(input string nm);
      out_t got, exp;
      got = {stallFetch, stallDecode, flushDecode, flushExecute,
             forward1Select, forward2Select, lostCycles};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got sf%b sd%b fd%b fe%b f1=%b f2=%b lost=%0d expected sf%b sd%b fd%b fe%b f1=%b f2=%b lost=%0d",
                  nm, got.sf, got.sd, got.fd, got.fe, got.f1, got.f2, got.lost,
                  exp.sf, exp.sd, exp.fd, exp.fe, exp.f1, exp.f2, exp.lost);
      end
   endtask

   task automatic step(input in_t i, input out_t e, input string nm);
      @(negedge clock);
      drive(i);
      sb.push_back(e);
      #2;
      compare(nm);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, got, exp);
      end
   endtask

   in_t  idle;
   in_t  lu;
   vec_t vt[12];

   initial begin
      idle = fi(0,0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 0);
      lu   = fi(3,1, 0,0, 0,0, 3,1,1, 0,0, 0,0, 0);

      vt[0]  = '{idle, fo(0,0,0,0,2'b00,2'b00,0), "idle_after_reset"};
      vt[1]  = '{fi(0,0,0,0, 0,5, 0,0,0, 5,1, 5,1, 0), fo(0,0,0,0,2'b00,2'b10,0), "fwd_mem_beats_wb"};
      vt[2]  = '{fi(0,0,0,0, 0,5, 0,0,0, 5,0, 5,1, 0), fo(0,0,0,0,2'b00,2'b01,0), "fwd_wb_only"};
      vt[3]  = '{fi(0,0,0,0, 15,15, 0,0,0, 15,1, 15,1, 0), fo(0,0,0,0,2'b00,2'b00,0), "fwd_pcreg_none"};
      vt[4]  = '{fi(0,0,0,0, 7,9, 0,0,0, 7,1, 9,1, 0), fo(0,0,0,0,2'b10,2'b01,0), "fwd_mixed"};
      vt[5]  = '{fi(0,0,0,0, 4,0, 0,0,0, 0,0, 4,1, 0), fo(0,0,0,0,2'b01,2'b00,0), "fwd_wb_reg1"};
      vt[6]  = '{fi(3,0,0,0, 0,0, 3,1,1, 0,0, 0,0, 0), fo(0,0,0,0,2'b00,2'b00,0), "lu_src_unused"};
      vt[7]  = '{fi(15,1,0,0, 0,0, 15,1,1, 0,0, 0,0, 0), fo(0,0,0,0,2'b00,2'b00,0), "lu_pcreg"};
      vt[8]  = '{fi(3,1,0,0, 0,0, 3,0,1, 0,0, 0,0, 0), fo(0,0,0,0,2'b00,2'b00,0), "lu_no_regwrite"};
      vt[9]  = '{fi(3,1,0,0, 0,0, 3,1,0, 0,0, 0,0, 0), fo(0,0,0,0,2'b00,2'b00,0), "lu_not_load"};
      vt[10] = '{fi(0,0,4,1, 0,0, 3,1,1, 0,0, 0,0, 0), fo(0,0,0,0,2'b00,2'b00,0), "lu_reg2_mismatch"};
      vt[11] = '{fi(0,0,0,0, 6,0, 0,0,0, 6,0, 6,0, 0), fo(0,0,0,0,2'b00,2'b00,0), "fwd_no_writes"};

      reset = 1'b0;
      drive(idle);
      #2;
      chk("reset_outputs", {28'd0, stallFetch, stallDecode, flushDecode, flushExecute}, 32'd0);
      chk("reset_fwd", {28'd0, forward1Select, forward2Select}, 32'd0);
      chk("reset_lost", {16'd0, lostCycles}, 32'd0);
      @(negedge clock);
      reset = 1'b1;

      foreach (vt[k]) step(vt[k].i, vt[k].o, vt[k].nm);

      // load-use: one bubble, then memory-stage forwarding; the held hazard is ignored
      step(lu, fo(1,1,0,1,2'b00,2'b00,0), "lu_stall");
      step(fi(3,1,0,0, 3,0, 3,1,1, 3,1, 0,0, 0), fo(0,0,0,0,2'b10,2'b00,1), "lu_after_stall");
      step(idle, fo(0,0,0,0,2'b00,2'b00,1), "lu_done");

      // branch: two flush cycles, second branch and hazard ignored in FLUSH
      step(fi(0,0,0,0, 0,0, 0,0,0, 0,0, 0,0, 1), fo(0,0,1,1,2'b00,2'b00,1), "br_cycle1");
      step(fi(3,1,0,0, 0,0, 3,1,1, 0,0, 0,0, 1), fo(0,0,1,1,2'b00,2'b00,2), "br_cycle2");
      step(idle, fo(0,0,0,0,2'b00,2'b00,3), "br_done");

      // hazard and branch together: flush wins
      step(fi(0,0,3,1, 0,0, 3,1,1, 0,0, 0,0, 1), fo(0,0,1,1,2'b00,2'b00,3), "simul_flush");
      step(idle, fo(0,0,1,1,2'b00,2'b00,4), "simul_in_flush");
      step(idle, fo(0,0,0,0,2'b00,2'b00,5), "simul_done");

      // branch arriving in LOADSTALL
      step(lu, fo(1,1,0,1,2'b00,2'b00,5), "ls_stall");
      step(fi(3,1,0,0, 0,0, 3,1,1, 0,0, 0,0, 1), fo(0,0,1,1,2'b00,2'b00,6), "ls_branch");
      step(idle, fo(0,0,1,1,2'b00,2'b00,7), "ls_in_flush");
      step(idle, fo(0,0,0,0,2'b00,2'b00,8), "ls_done");

      // reset in the first FLUSH cycle
      step(fi(0,0,0,0, 0,0, 0,0,0, 0,0, 0,0, 1), fo(0,0,1,1,2'b00,2'b00,8), "rst_br");
      step(idle, fo(0,0,1,1,2'b00,2'b00,9), "rst_in_flush");
      #1;
      reset = 1'b0;
      #1;
      chk("rst_async_outputs", {28'd0, stallFetch, stallDecode, flushDecode, flushExecute}, 32'd0);
      chk("rst_async_lost", {16'd0, lostCycles}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      step(idle, fo(0,0,0,0,2'b00,2'b00,0), "rst_released_idle");
      step(lu, fo(1,1,0,1,2'b00,2'b00,0), "rst_run_stalls");
      step(idle, fo(0,0,0,0,2'b00,2'b00,1), "rst_run_done");

      // saturation under a continuous redirect stream
      @(negedge clock);
      drive(fi(0,0,0,0, 0,0, 0,0,0, 0,0, 0,0, 1));
      repeat (65540) @(posedge clock);
      #1;
      chk("sat_hold", {16'd0, lostCycles}, 32'h0000_FFFF);
      @(negedge clock);
      drive(idle);
      repeat (4) @(posedge clock);
      #1;
      chk("sat_no_wrap", {16'd0, lostCycles}, 32'h0000_FFFF);
      chk("sat_flush_clear", {31'd0, flushExecute}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
